// File: rtl/spi_reg_defs.sv
// Shared frame layout and FSM encoding for the SPI register bank.
package spi_reg_defs;

  // Frame controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // Number of R/W bits at the head of every frame
  localparam int RW_BITS = 1;

  // Total frame length: R/W + address + data
  function automatic int frame_bits(input int addr_w, input int data_w);
    return RW_BITS + addr_w + data_w;
  endfunction

  // Header length: R/W + address
  function automatic int hdr_bits(input int addr_w);
    return RW_BITS + addr_w;
  endfunction

  // Field offsets inside the received shift register (last bit received at bit 0)
  function automatic int data_lsb();
    return 0;
  endfunction

  function automatic int addr_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int rw_pos(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin, with edge detect
// on the synchronized level.
module spi_sync #(
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta, sync, prev;

  // Synchronizer chain plus one history flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= IDLE_VAL;
      sync <= IDLE_VAL;
      prev <= IDLE_VAL;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave giving read/write access to a small bank of registers.
// All SPI pins are oversampled in the clk domain.
module spi_reg_bank
  import spi_reg_defs::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 4,
  parameter int                NREG      = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sclk,
  input  logic                   cs,
  input  logic                   mosi,
  output logic                   miso,
  output logic [NREG*DATA_W-1:0] reg_out,
  output logic                   wr_stb,
  output logic [ADDR_W-1:0]      wr_addr
);

  localparam int FB    = frame_bits(ADDR_W, DATA_W);
  localparam int HB    = hdr_bits(ADDR_W);
  localparam int CNT_W = $clog2(FB + 2);
  localparam int A_LSB = addr_lsb(DATA_W);
  localparam int D_LSB = data_lsb();
  localparam int RW_IX = rw_pos(ADDR_W, DATA_W);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_inc;
  logic              ovl, rd;
  logic [FB-1:0]     shreg;
  logic [DATA_W-1:0] oreg, rd_val;
  logic [DATA_W-1:0] regs [NREG];
  logic [HB-1:0]     hdr_word;
  logic [ADDR_W-1:0] addr_fld;
  logic              sclk_lvl, sclk_rise, sclk_fall;
  logic              cs_lvl, cs_rise, cs_fall;
  logic              mosi_lvl, mosi_rise, mosi_fall;
  logic              sync_unused;
  logic              hdr_done, commit, addr_ok, shift_out, shift_in;

  spi_sync #(.IDLE_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync #(.IDLE_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .din(cs), .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );
  spi_sync #(.IDLE_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(mosi), .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign sync_unused = ^{sclk_lvl, cs_lvl, mosi_rise, mosi_fall};

  // Counter saturates one past a full frame so over-length frames never match
  assign cnt_inc   = (cnt == CNT_W'(FB + 1)) ? cnt : cnt + 1'b1;
  // Header as it will stand once the current mosi bit is shifted in
  assign hdr_word  = {shreg[HB-2:0], mosi_lvl};
  assign hdr_done  = (state == ST_HDR) && sclk_rise && !cs_rise && (cnt_inc == CNT_W'(HB));
  assign addr_fld  = shreg[A_LSB +: ADDR_W];
  assign addr_ok   = ({1'b0, addr_fld} < (ADDR_W + 1)'(NREG));
  assign commit    = cs_rise && (cnt == CNT_W'(FB)) && !ovl && !shreg[RW_IX] && addr_ok;
  assign shift_in  = sclk_rise && !cs_rise && (state == ST_HDR || state == ST_DATA);
  assign shift_out = sclk_fall && !cs_rise && rd && (state == ST_DATA || state == ST_HOLD);

  // Read source for the addressed register; unimplemented addresses read 0
  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NREG; k++)
      if (hdr_word[ADDR_W-1:0] == ADDR_W'(k)) rd_val = regs[k];
  end

  // Next-state logic; cs rising edge overrides any sclk activity
  always_comb begin
    state_nxt = state;
    if (cs_rise) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (cs_fall) state_nxt = ST_HDR;
        ST_HDR:  if (sclk_rise && cnt_inc == CNT_W'(HB)) state_nxt = ST_DATA;
        ST_DATA: if (sclk_rise && cnt_inc == CNT_W'(FB)) state_nxt = ST_HOLD;
        default: state_nxt = state;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Bit counter, frame flags, miso and write strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      ovl     <= 1'b0;
      rd      <= 1'b0;
      miso    <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
    end else begin
      wr_stb <= commit;
      if (commit) wr_addr <= addr_fld;
      if (cs_rise) begin
        cnt  <= '0;
        ovl  <= 1'b0;
        rd   <= 1'b0;
        miso <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (cs_fall) begin
            cnt <= '0;
            ovl <= 1'b0;
            rd  <= 1'b0;
          end
          ST_HDR: if (sclk_rise) begin
            cnt <= cnt_inc;
            if (hdr_done) rd <= hdr_word[HB-1];
          end
          ST_DATA: if (sclk_rise) cnt <= cnt_inc;
          default: if (sclk_rise) begin
            cnt <= cnt_inc;
            ovl <= 1'b1;
          end
        endcase
        if (shift_out) miso <= oreg[DATA_W-1];
      end
    end
  end

  // Receive and transmit shift registers
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && cs_fall && !cs_rise) shreg <= '0;
    else if (shift_in)                           shreg <= {shreg[FB-2:0], mosi_lvl};
    if (hdr_done)       oreg <= rd_val;
    else if (shift_out) oreg <= oreg << 1;
  end

  // Register bank: loaded only by a committed write frame
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) regs[k] <= RESET_VAL;
    end else if (commit) begin
      for (int k = 0; k < NREG; k++)
        if (addr_fld == ADDR_W'(k)) regs[k] <= shreg[D_LSB +: DATA_W];
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_out
    assign reg_out[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Testbench for spi_reg_bank: directed frame table, mid-frame reset,
// back-to-back frames and random frames against a register-array model.
module tb_spi_reg_bank;
  import spi_reg_defs::*;

  localparam int          DATA_W    = 8;
  localparam int          ADDR_W    = 4;
  localparam int          NREG      = 4;
  localparam logic [7:0]  RESET_VAL = 8'h3C;
  localparam int          FB        = frame_bits(ADDR_W, DATA_W);
  localparam int          HB        = hdr_bits(ADDR_W);
  localparam time         HALF      = 60ns;

  logic                   clk = 1'b0;
  logic                   rst, sclk, cs, mosi;
  logic                   miso;
  logic [NREG*DATA_W-1:0] reg_out;
  logic                   wr_stb;
  logic [ADDR_W-1:0]      wr_addr;

  spi_reg_bank #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG), .RESET_VAL(RESET_VAL)
  ) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
    .miso(miso), .reg_out(reg_out), .wr_stb(wr_stb), .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Count every clk cycle with wr_stb high and remember the address shown
  int                stb_cycles = 0;
  logic [ADDR_W-1:0] last_wr_addr = '0;
  always @(negedge clk) begin
    if (wr_stb === 1'b1) begin
      stb_cycles   <= stb_cycles + 1;
      last_wr_addr <= wr_addr;
    end
  end

  // Reference model: plain array of register values
  logic [DATA_W-1:0] model [NREG];

  task automatic model_reset();
    for (int k = 0; k < NREG; k++) model[k] = RESET_VAL;
  endtask

  function automatic logic [NREG*DATA_W-1:0] model_flat();
    logic [NREG*DATA_W-1:0] f;
    f = '0;
    for (int k = 0; k < NREG; k++) f[k*DATA_W +: DATA_W] = model[k];
    return f;
  endfunction

  // Expected miso samples, one per sclk rise, first sample in the highest used bit
  function automatic logic [31:0] exp_miso(input logic is_rd, input logic [DATA_W-1:0] rdata,
                                           input int nbits);
    logic [31:0] e;
    logic        b;
    e = '0;
    for (int k = 0; k < nbits; k++) begin
      b = (is_rd && k >= HB && k < FB) ? rdata[DATA_W-1-(k-HB)] : 1'b0;
      e = {e[30:0], b};
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one SPI frame; optionally pulse rst after bit number rst_after
  task automatic run_frame(input logic rw, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data, input int nbits,
                           input int rst_after, input int gap_half,
                           output logic [31:0] cap);
    logic [FB-1:0] word;
    logic          b;
    word = {rw, addr, data};
    cap  = '0;
    cs = 1'b0;
    #HALF;
    for (int k = 0; k < nbits; k++) begin
      b    = (k < FB) ? word[FB-1-k] : 1'b0;
      mosi = b;
      #HALF;
      cap  = {cap[30:0], miso};
      sclk = 1'b1;
      #HALF;
      sclk = 1'b0;
      if (k + 1 == rst_after) begin
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
      end
    end
    #HALF;
    cs   = 1'b1;
    mosi = 1'b0;
    repeat (gap_half) #HALF;
  endtask

  // Run a frame and compare strobe count, strobe address, registers and miso
  task automatic do_frame(input string tag, input logic rw, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] data, input int nbits,
                          input int rst_after, input int gap_half, input logic exp_commit);
    logic [31:0]       cap;
    logic [DATA_W-1:0] rdata;
    int                stb0;
    rdata = (int'(addr) < NREG) ? model[addr[1:0]] : '0;
    stb0  = stb_cycles;
    run_frame(rw, addr, data, nbits, rst_after, gap_half, cap);
    check({tag, "_stb"}, 64'(stb_cycles - stb0), 64'(exp_commit));
    if (exp_commit) begin
      check({tag, "_waddr"}, 64'(last_wr_addr), 64'(addr));
      model[addr[1:0]] = data;
    end
    check({tag, "_regs"}, 64'(reg_out), 64'(model_flat()));
    check({tag, "_miso"}, 64'(cap), 64'(exp_miso(rw, rdata, nbits)));
  endtask

  typedef struct {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                nbits;
    int                rst_after;
    int                gap_half;
    logic              commit;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                nbits;
    logic              expc;

    tbl[0]  = '{1'b0, 4'd2, 8'hA5, 13, 0, 4, 1'b1};  // write A5 to reg 2
    tbl[1]  = '{1'b1, 4'd2, 8'h00, 13, 0, 4, 1'b0};  // read it back
    tbl[2]  = '{1'b0, 4'd1, 8'hFF, 12, 0, 4, 1'b0};  // short frame
    tbl[3]  = '{1'b0, 4'd1, 8'hFF, 14, 0, 4, 1'b0};  // long frame
    tbl[4]  = '{1'b0, 4'd7, 8'h77, 13, 0, 4, 1'b0};  // out-of-range write
    tbl[5]  = '{1'b1, 4'd7, 8'h00, 13, 0, 4, 1'b0};  // out-of-range read
    tbl[6]  = '{1'b0, 4'd3, 8'hC3, 13, 0, 4, 1'b1};  // write before reset
    tbl[7]  = '{1'b0, 4'd0, 8'h99, 13, 6, 4, 1'b0};  // reset after 6th bit
    tbl[8]  = '{1'b0, 4'd0, 8'h11, 13, 0, 2, 1'b1};  // back-to-back, short gap
    tbl[9]  = '{1'b0, 4'd3, 8'h22, 13, 0, 4, 1'b1};
    tbl[10] = '{1'b1, 4'd3, 8'h00, 13, 0, 4, 1'b0};  // read 22
    tbl[11] = '{1'b1, 4'd1, 8'h00, 14, 0, 4, 1'b0};  // over-length read
    tbl[12] = '{1'b1, 4'd0, 8'h00, 12, 0, 4, 1'b0};  // short read

    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    model_reset();
    repeat (4) @(posedge clk);
    #1;
    check("rst_regs",   64'(reg_out), 64'(model_flat()));
    check("rst_miso",   64'(miso),    64'd0);
    check("rst_wr_stb", 64'(wr_stb),  64'd0);
    check("rst_waddr",  64'(wr_addr), 64'd0);
    @(negedge clk) rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_regs", 64'(reg_out), 64'(model_flat()));
    check("idle_miso", 64'(miso),    64'd0);

    for (int i = 0; i < 13; i++)
      do_frame($sformatf("vec%0d", i), tbl[i].rw, tbl[i].addr, tbl[i].data, tbl[i].nbits,
               tbl[i].rst_after, tbl[i].gap_half, tbl[i].commit);

    // Hand-written: cs pulsed low with no sclk activity must not commit
    begin
      int stb0;
      stb0 = stb_cycles;
      cs = 1'b0;
      repeat (3) #HALF;
      cs = 1'b1;
      repeat (3) #HALF;
      check("empty_frame_stb",  64'(stb_cycles - stb0), 64'd0);
      check("empty_frame_regs", 64'(reg_out), 64'(model_flat()));
    end

    // Random frames against the model
    for (int i = 0; i < 24; i++) begin
      rw    = 1'($urandom_range(0, 1));
      addr  = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(0, 15))
                                          : ADDR_W'($urandom_range(0, NREG - 1));
      data  = DATA_W'($urandom);
      case ($urandom_range(0, 4))
        0:       nbits = FB - 1;
        1:       nbits = FB + 1;
        default: nbits = FB;
      endcase
      expc = (nbits == FB) && !rw && (int'(addr) < NREG);
      do_frame($sformatf("rnd%0d", i), rw, addr, data, nbits, 0, 3, expc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
